stream_packet_fifo: RTL and testbench

Store-and-forward Avalon-ST packet FIFO that sits directly downstream of the endian swapper stage. It buffers whole packets and presents a packet to its consumer only after the packet's end-of-packet beat has been stored, so downstream never sees a stalled mid-packet bubble caused by upstream. It discards oversize packets and exposes fill level, packet and drop counters, and a flush control over a small Avalon-MM CSR bus.

---
 rtl/stream_fifo_pkg.sv | 19 +
 rtl/stream_packet_fifo_if.sv | 52 +++++
 rtl/stream_fifo_ram.sv | 23 ++
 rtl/stream_packet_fifo.sv | 160 ++++++++++++++++
 tb/tb_stream_packet_fifo.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_fifo_pkg.sv
// Shared definitions for the store-and-forward packet FIFO: CSR map, input FSM states
// and a saturating counter helper.
package stream_fifo_pkg;

    localparam logic [1:0] ADDR_FILL  = 2'd0;
    localparam logic [1:0] ADDR_PKTS  = 2'd1;
    localparam logic [1:0] ADDR_DROPS = 2'd2;
    localparam logic [1:0] ADDR_CTRL  = 2'd3;

    typedef enum logic {
        PASS,
        DROP
    } in_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/stream_packet_fifo_if.sv
// Avalon-ST in/out and Avalon-MM CSR bundle for stream_packet_fifo.
interface stream_packet_fifo_if #(
    parameter int DATA_BYTES = 8
);
    localparam int DATA_W  = DATA_BYTES * 8;
    localparam int EMPTY_W = $clog2(DATA_BYTES);

    logic [DATA_W-1:0]  stream_in_data;
    logic [EMPTY_W-1:0] stream_in_empty;
    logic               stream_in_valid;
    logic               stream_in_startofpacket;
    logic               stream_in_endofpacket;
    logic               stream_in_ready;

    logic [DATA_W-1:0]  stream_out_data;
    logic [EMPTY_W-1:0] stream_out_empty;
    logic               stream_out_valid;
    logic               stream_out_startofpacket;
    logic               stream_out_endofpacket;
    logic               stream_out_ready;

    logic [1:0]         csr_address;
    logic               csr_read;
    logic               csr_write;
    logic [31:0]        csr_writedata;
    logic [31:0]        csr_readdata;
    logic               csr_readdatavalid;
    logic               csr_waitrequest;

    modport slave (
        input  stream_in_data, stream_in_empty, stream_in_valid,
               stream_in_startofpacket, stream_in_endofpacket,
        output stream_in_ready,
        output stream_out_data, stream_out_empty, stream_out_valid,
               stream_out_startofpacket, stream_out_endofpacket,
        input  stream_out_ready,
        input  csr_address, csr_read, csr_write, csr_writedata,
        output csr_readdata, csr_readdatavalid, csr_waitrequest
    );

    modport master (
        output stream_in_data, stream_in_empty, stream_in_valid,
               stream_in_startofpacket, stream_in_endofpacket,
        input  stream_in_ready,
        input  stream_out_data, stream_out_empty, stream_out_valid,
               stream_out_startofpacket, stream_out_endofpacket,
        output stream_out_ready,
        output csr_address, csr_read, csr_write, csr_writedata,
        input  csr_readdata, csr_readdatavalid, csr_waitrequest
    );

endinterface

// File: rtl/stream_fifo_ram.sv
// Beat storage: synchronous write, asynchronous (fall-through) read.
module stream_fifo_ram #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_packet_fifo.sv
// Store-and-forward packet FIFO: releases a packet only once its EOP is stored,
// drops oversize/stray traffic, and exposes counters and flush over CSR.
module stream_packet_fifo
    import stream_fifo_pkg::*;
#(
    parameter int DATA_BYTES = 8,
    parameter int DEPTH      = 16
) (
    input logic                 clk,
    input logic                 reset_n,
    stream_packet_fifo_if.slave bus
);

    localparam int AW      = $clog2(DEPTH);
    localparam int PW      = AW + 1;
    localparam int DATA_W  = DATA_BYTES * 8;
    localparam int EMPTY_W = $clog2(DATA_BYTES);

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [EMPTY_W-1:0] empty;
        logic               sop;
        logic               eop;
    } beat_t;

    in_state_t   in_state;
    logic [PW-1:0] wr_ptr, rd_ptr, pkt_start_ptr, complete_pkts, fill;
    logic        in_pkt, last_out_eop, flush_pending;
    logic [31:0] pkt_out_count, drop_count;
    logic        rd_req;
    logic [1:0]  rd_addr;
    logic [31:0] csr_mux;
    beat_t       wr_beat, rd_beat;
    logic        full, flush_go, in_ready, in_acc, out_valid, out_xfer, out_eop_xfer;
    logic        stray, oversize, wr_en, wr_eop, flush_mid;
    logic        unused_wdata;

    assign unused_wdata = ^bus.csr_writedata[31:1];

    always_comb begin
        fill         = wr_ptr - rd_ptr;
        full         = (fill == PW'(DEPTH));
        flush_go     = flush_pending && last_out_eop;
        in_ready     = (in_state == DROP) || !full || (complete_pkts == '0);
        in_acc       = bus.stream_in_valid && in_ready;
        // Gating valid during the flush cycle keeps a new packet from starting just as it is discarded.
        out_valid    = (complete_pkts != '0) && !flush_go;
        out_xfer     = out_valid && bus.stream_out_ready;
        out_eop_xfer = out_xfer && rd_beat.eop;
        stray        = (in_state == PASS) && in_acc && !in_pkt && !bus.stream_in_startofpacket;
        oversize     = (in_state == PASS) && in_acc && full && !stray;
        wr_en        = (in_state == PASS) && in_acc && !full && !stray && !flush_go;
        wr_eop       = wr_en && bus.stream_in_endofpacket;
        flush_mid    = (in_state == DROP)
                     ? !(in_acc && bus.stream_in_endofpacket)
                     : (in_acc ? ((in_pkt || bus.stream_in_startofpacket) && !bus.stream_in_endofpacket)
                               : in_pkt);
    end

    always_comb begin
        wr_beat.data  = bus.stream_in_data;
        wr_beat.empty = bus.stream_in_empty;
        wr_beat.sop   = bus.stream_in_startofpacket;
        wr_beat.eop   = bus.stream_in_endofpacket;
    end

    stream_fifo_ram #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_beat),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_beat)
    );

    assign bus.stream_in_ready          = in_ready;
    assign bus.stream_out_valid         = out_valid;
    assign bus.stream_out_data          = rd_beat.data;
    assign bus.stream_out_empty         = rd_beat.empty;
    assign bus.stream_out_startofpacket = rd_beat.sop;
    assign bus.stream_out_endofpacket   = rd_beat.eop;
    assign bus.csr_waitrequest          = 1'b0;

    always_comb begin
        csr_mux = '0;
        case (rd_addr)
            ADDR_FILL:  csr_mux = 32'(fill);
            ADDR_PKTS:  csr_mux = pkt_out_count;
            ADDR_DROPS: csr_mux = drop_count;
            default:    csr_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_state              <= PASS;
            wr_ptr                <= '0;
            rd_ptr                <= '0;
            pkt_start_ptr         <= '0;
            complete_pkts         <= '0;
            in_pkt                <= 1'b0;
            last_out_eop          <= 1'b1;
            flush_pending         <= 1'b0;
            pkt_out_count         <= '0;
            drop_count            <= '0;
            rd_req                <= 1'b0;
            rd_addr               <= '0;
            bus.csr_readdata      <= '0;
            bus.csr_readdatavalid <= 1'b0;
        end else begin
            if (out_xfer) begin
                rd_ptr       <= rd_ptr + PW'(1);
                last_out_eop <= rd_beat.eop;
                if (rd_beat.eop) pkt_out_count <= pkt_out_count + 32'd1;
            end

            if (flush_go) begin
                flush_pending <= 1'b0;
                wr_ptr        <= rd_ptr;
                pkt_start_ptr <= rd_ptr;
                complete_pkts <= '0;
                in_pkt        <= 1'b0;
                in_state      <= flush_mid ? DROP : PASS;
            end else begin
                complete_pkts <= complete_pkts + PW'(wr_eop) - PW'(out_eop_xfer);
                case (in_state)
                    PASS: begin
                        if (stray) begin
                            drop_count <= sat_inc(drop_count);
                        end else if (oversize) begin
                            wr_ptr     <= pkt_start_ptr;
                            drop_count <= sat_inc(drop_count);
                            in_pkt     <= 1'b0;
                            if (!bus.stream_in_endofpacket) in_state <= DROP;
                        end else if (wr_en) begin
                            if (bus.stream_in_startofpacket) pkt_start_ptr <= wr_ptr;
                            wr_ptr <= wr_ptr + PW'(1);
                            in_pkt <= !bus.stream_in_endofpacket;
                        end
                    end
                    DROP: begin
                        if (in_acc && bus.stream_in_endofpacket) in_state <= PASS;
                    end
                endcase
            end

            if (bus.csr_write && bus.csr_address == ADDR_CTRL && bus.csr_writedata[0])
                flush_pending <= 1'b1;

            rd_req                <= bus.csr_read;
            rd_addr               <= bus.csr_address;
            bus.csr_readdatavalid <= rd_req;
            bus.csr_readdata      <= rd_req ? csr_mux : '0;
        end
    end

endmodule

// File: tb/tb_stream_packet_fifo.sv
// Directed self-checking bench for stream_packet_fifo (DATA_BYTES=8, DEPTH=16).
module tb_stream_packet_fifo;

    localparam int DATA_BYTES = 8;
    localparam int DEPTH      = 16;
    localparam int EMPTY_W    = $clog2(DATA_BYTES);

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    stream_packet_fifo_if #(.DATA_BYTES(DATA_BYTES)) bus ();

    stream_packet_fifo #(
        .DATA_BYTES (DATA_BYTES),
        .DEPTH      (DEPTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pd(input int p, input int b);
        return 64'hA5A5_0000_0000_0000 | (64'(p) << 16) | 64'(b);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input logic sop, input logic eop);
        bit acc = 1'b0;
        bus.stream_in_data          = d;
        bus.stream_in_empty         = eop ? EMPTY_W'(5) : '0;
        bus.stream_in_startofpacket = sop;
        bus.stream_in_endofpacket   = eop;
        bus.stream_in_valid         = 1'b1;
        for (int i = 0; i < 64 && !acc; i++) begin
            acc = bus.stream_in_ready;
            step();
        end
        bus.stream_in_valid         = 1'b0;
        bus.stream_in_startofpacket = 1'b0;
        bus.stream_in_endofpacket   = 1'b0;
        if (!acc) check("send_accept", 64'(acc), 64'd1);
    endtask

    task automatic head_chk(input string tag, input logic [63:0] d, input logic sop, input logic eop);
        check({tag, "_valid"}, 64'(bus.stream_out_valid), 64'd1);
        check({tag, "_data"},  bus.stream_out_data, d);
        check({tag, "_sop"},   64'(bus.stream_out_startofpacket), 64'(sop));
        check({tag, "_eop"},   64'(bus.stream_out_endofpacket), 64'(eop));
        if (eop) check({tag, "_empty"}, 64'(bus.stream_out_empty), 64'd5);
    endtask

    task automatic recv(input string tag, input logic [63:0] d, input logic sop, input logic eop);
        bit seen = 1'b0;
        bus.stream_out_ready = 1'b1;
        for (int i = 0; i < 64 && !seen; i++) begin
            if (bus.stream_out_valid) seen = 1'b1;
            else step();
        end
        head_chk(tag, d, sop, eop);
        step();
    endtask

    task automatic csr_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        bus.csr_read    = 1'b1;
        bus.csr_address = a;
        step();
        bus.csr_read = 1'b0;
        step();
        check({tag, "_rdvalid"}, 64'(bus.csr_readdatavalid), 64'd1);
        check(tag, 64'(bus.csr_readdata), 64'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.stream_in_data          = '0;
        bus.stream_in_empty         = '0;
        bus.stream_in_valid         = 1'b0;
        bus.stream_in_startofpacket = 1'b0;
        bus.stream_in_endofpacket   = 1'b0;
        bus.stream_out_ready        = 1'b0;
        bus.csr_address             = '0;
        bus.csr_read                = 1'b0;
        bus.csr_write               = 1'b0;
        bus.csr_writedata           = '0;

        // Reset values
        repeat (2) step();
        check("rst_out_valid", 64'(bus.stream_out_valid), 64'd0);
        check("rst_in_ready",  64'(bus.stream_in_ready), 64'd1);
        check("rst_rdvalid",   64'(bus.csr_readdatavalid), 64'd0);
        check("rst_rddata",    64'(bus.csr_readdata), 64'd0);
        check("rst_waitreq",   64'(bus.csr_waitrequest), 64'd0);
        reset_n = 1'b1;
        step();
        csr_chk("rst_fill", 2'd0, 32'd0);

        // Single 3-beat packet, output ready held high
        bus.stream_out_ready = 1'b1;
        send(pd(1, 0), 1'b1, 1'b0);
        check("t1_valid_b0", 64'(bus.stream_out_valid), 64'd0);
        send(pd(1, 1), 1'b0, 1'b0);
        check("t1_valid_b1", 64'(bus.stream_out_valid), 64'd0);
        send(pd(1, 2), 1'b0, 1'b1);
        head_chk("t1_b0", pd(1, 0), 1'b1, 1'b0);
        step();
        head_chk("t1_b1", pd(1, 1), 1'b0, 1'b0);
        step();
        head_chk("t1_b2", pd(1, 2), 1'b0, 1'b1);
        step();
        check("t1_valid_end", 64'(bus.stream_out_valid), 64'd0);
        csr_chk("t1_pkts", 2'd1, 32'd1);

        // Four 4-beat packets fill the FIFO while downstream stalls
        bus.stream_out_ready = 1'b0;
        for (int p = 0; p < 4; p++)
            for (int b = 0; b < 4; b++)
                send(pd(2 + p, b), b == 0, b == 3);
        check("t2_in_ready_full", 64'(bus.stream_in_ready), 64'd0);
        csr_chk("t2_fill", 2'd0, 32'd16);
        for (int p = 0; p < 4; p++)
            for (int b = 0; b < 4; b++)
                recv("t2_drain", pd(2 + p, b), b == 0, b == 3);
        check("t2_valid_end", 64'(bus.stream_out_valid), 64'd0);
        csr_chk("t2_fill_end", 2'd0, 32'd0);
        csr_chk("t2_pkts", 2'd1, 32'd5);

        // 20-beat oversize packet is dropped, next packet passes
        bus.stream_out_ready = 1'b0;
        for (int b = 0; b < 20; b++) begin
            check("t3_in_ready", 64'(bus.stream_in_ready), 64'd1);
            send(pd(10, b), b == 0, b == 19);
        end
        check("t3_valid", 64'(bus.stream_out_valid), 64'd0);
        csr_chk("t3_drops", 2'd2, 32'd1);
        csr_chk("t3_fill", 2'd0, 32'd0);
        send(pd(11, 0), 1'b1, 1'b0);
        send(pd(11, 1), 1'b0, 1'b1);
        recv("t3_next_b0", pd(11, 0), 1'b1, 1'b0);
        recv("t3_next_b1", pd(11, 1), 1'b0, 1'b1);
        csr_chk("t3_pkts", 2'd1, 32'd6);

        // EOP written and EOP read in the same cycle with two packets stored
        bus.stream_out_ready = 1'b0;
        send(pd(20, 0), 1'b1, 1'b0);
        send(pd(20, 1), 1'b0, 1'b1);
        send(pd(21, 0), 1'b1, 1'b0);
        send(pd(21, 1), 1'b0, 1'b1);
        send(pd(22, 0), 1'b1, 1'b0);
        bus.stream_out_ready = 1'b1;
        head_chk("t4_p0", pd(20, 0), 1'b1, 1'b0);
        step();
        head_chk("t4_p1", pd(20, 1), 1'b0, 1'b1);
        bus.stream_in_data          = pd(22, 1);
        bus.stream_in_empty         = EMPTY_W'(5);
        bus.stream_in_startofpacket = 1'b0;
        bus.stream_in_endofpacket   = 1'b1;
        bus.stream_in_valid         = 1'b1;
        check("t4_r1_ready", 64'(bus.stream_in_ready), 64'd1);
        step();
        bus.stream_in_valid       = 1'b0;
        bus.stream_in_endofpacket = 1'b0;
        head_chk("t4_q0", pd(21, 0), 1'b1, 1'b0);
        step();
        head_chk("t4_q1", pd(21, 1), 1'b0, 1'b1);
        step();
        head_chk("t4_r0", pd(22, 0), 1'b1, 1'b0);
        step();
        head_chk("t4_r1", pd(22, 1), 1'b0, 1'b1);
        step();
        check("t4_valid_end", 64'(bus.stream_out_valid), 64'd0);
        csr_chk("t4_pkts", 2'd1, 32'd9);

        // Flush requested mid-output waits for EOP; partial input packet is dropped
        bus.stream_out_ready = 1'b0;
        for (int b = 0; b < 4; b++) send(pd(30, b), b == 0, b == 3);
        send(pd(31, 0), 1'b1, 1'b0);
        send(pd(31, 1), 1'b0, 1'b0);
        bus.stream_out_ready = 1'b1;
        head_chk("t5_f0", pd(30, 0), 1'b1, 1'b0);
        step();
        head_chk("t5_f1", pd(30, 1), 1'b0, 1'b0);
        step();
        head_chk("t5_f2", pd(30, 2), 1'b0, 1'b0);
        bus.csr_write     = 1'b1;
        bus.csr_address   = 2'd3;
        bus.csr_writedata = 32'd1;
        step();
        bus.csr_write     = 1'b0;
        bus.csr_writedata = '0;
        head_chk("t5_f3", pd(30, 3), 1'b0, 1'b1);
        step();
        check("t5_valid_flush", 64'(bus.stream_out_valid), 64'd0);
        step();
        send(pd(31, 2), 1'b0, 1'b0);
        send(pd(31, 3), 1'b0, 1'b1);
        check("t5_valid_dropped", 64'(bus.stream_out_valid), 64'd0);
        csr_chk("t5_fill", 2'd0, 32'd0);
        csr_chk("t5_drops", 2'd2, 32'd1);
        csr_chk("t5_ctrl_rd", 2'd3, 32'd0);
        send(pd(32, 0), 1'b1, 1'b0);
        send(pd(32, 1), 1'b0, 1'b1);
        recv("t5_k0", pd(32, 0), 1'b1, 1'b0);
        recv("t5_k1", pd(32, 1), 1'b0, 1'b1);
        csr_chk("t5_pkts", 2'd1, 32'd11);

        // Reset mid-packet with 5 beats stored
        bus.stream_out_ready = 1'b0;
        for (int b = 0; b < 3; b++) send(pd(40, b), b == 0, b == 2);
        send(pd(41, 0), 1'b1, 1'b0);
        send(pd(41, 1), 1'b0, 1'b0);
        check("t6_valid_pre", 64'(bus.stream_out_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        check("t6_valid_rst", 64'(bus.stream_out_valid), 64'd0);
        check("t6_ready_rst", 64'(bus.stream_in_ready), 64'd1);
        step();
        reset_n = 1'b1;
        step();
        csr_chk("t6_fill", 2'd0, 32'd0);
        csr_chk("t6_pkts", 2'd1, 32'd0);
        csr_chk("t6_drops", 2'd2, 32'd0);
        send(pd(42, 1), 1'b0, 1'b0);
        check("t6_valid_stray", 64'(bus.stream_out_valid), 64'd0);
        csr_chk("t6_drops_stray", 2'd2, 32'd1);
        csr_chk("t6_fill_stray", 2'd0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
